// File: rtl/ga23_sdr_responder_if.sv
// Bundles the GA23 layer request ports and the shared SDRAM read channel.
// Latency: none; plain wiring with modports.
// Backpressure: none here; ram_req is held until ram_ack, and port_rdy is a one-cycle pulse.
interface ga23_sdr_responder_if #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 22
);
  logic [NUM_PORTS-1:0]        port_req;
  logic [NUM_PORTS*ADDR_W-1:0] port_addr;
  logic [NUM_PORTS*32-1:0]     port_data;
  logic [NUM_PORTS-1:0]        port_rdy;
  logic                        ram_req;
  logic [ADDR_W-1:0]           ram_addr;
  logic                        ram_ack;
  logic [31:0]                 ram_data;
  logic                        busy;

  // The responder side: it takes layer requests and SDRAM returns, and it
  // drives row data, the read request and busy.
  modport slave (
    input  port_req, port_addr, ram_ack, ram_data,
    output port_data, port_rdy, ram_req, ram_addr, busy
  );

  // The environment side: the layers plus the SDRAM controller.
  modport master (
    output port_req, port_addr, ram_ack, ram_data,
    input  port_data, port_rdy, ram_req, ram_addr, busy
  );
endinterface

// File: rtl/ga23_sdr_responder.sv
// Arbitrates GA23 layer tile-row fetches onto one SDRAM read channel and returns the data per port.
// Latency: a request pulse at edge n raises ram_req after edge n+1; ram_ack at edge m gives port_rdy after edge m.
// Backpressure: one read in flight, ram_req held until ack; data for a port that re-requested mid-read is dropped.
// Build option: define GA23_SDR_FIXED_PRIO_EN for fixed lowest-index priority; the default is round-robin.
module ga23_sdr_responder #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 22
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ga23_sdr_responder_if.slave   bus
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t                  state;
  logic [NUM_PORTS-1:0]    pending;
  logic [NUM_PORTS-1:0]    stale;
  logic [ADDR_W-1:0]       addr_q [NUM_PORTS];
  logic [PW-1:0]           gnt_q;
  logic [NUM_PORTS*32-1:0] port_data_q;
  logic [NUM_PORTS-1:0]    port_rdy_q;
  logic                    ram_req_q;
  logic [ADDR_W-1:0]       ram_addr_q;
  logic                    busy_q;

  logic                    gnt_vld;
  logic [PW-1:0]           gnt_idx;
  logic [PW-1:0]           cand_idx;
  int                      cand;

`ifndef GA23_SDR_FIXED_PRIO_EN
  logic [PW-1:0]           rr_ptr;
`endif

  // Pick the next port to serve: the scan runs downward from the farthest
  // candidate, so the last hit is the nearest pending port in priority order.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand_idx = '0;
    cand     = 0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
`ifdef GA23_SDR_FIXED_PRIO_EN
      cand = i;
`else
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
`endif
      cand_idx = PW'(cand);
      if (pending[cand_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  // Request capture, the IDLE/BUSY read sequencer and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pending     <= '0;
      stale       <= '0;
      gnt_q       <= '0;
      port_data_q <= '0;
      port_rdy_q  <= '0;
      ram_req_q   <= 1'b0;
      ram_addr_q  <= '0;
      busy_q      <= 1'b0;
`ifndef GA23_SDR_FIXED_PRIO_EN
      rr_ptr      <= '0;
`endif
      for (int p = 0; p < NUM_PORTS; p++) begin
        addr_q[p] <= '0;
      end
    end else begin
      port_rdy_q <= '0;

      // The latest pulse on a port always wins, even while that port is pending.
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (bus.port_req[p]) begin
          pending[p] <= 1'b1;
          addr_q[p]  <= bus.port_addr[p*ADDR_W +: ADDR_W];
        end
      end

      case (state)
        IDLE: begin
          if (gnt_vld) begin
            ram_req_q  <= 1'b1;
            ram_addr_q <= addr_q[gnt_idx];
            if (!bus.port_req[gnt_idx]) begin
              pending[gnt_idx] <= 1'b0;
            end
            stale[gnt_idx] <= 1'b0;
            busy_q         <= 1'b1;
            gnt_q          <= gnt_idx;
            state          <= BUSY;
`ifndef GA23_SDR_FIXED_PRIO_EN
            rr_ptr <= (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
`endif
          end
        end

        BUSY: begin
          // A fresh request from the owner makes the read in flight obsolete.
          if (bus.port_req[gnt_q]) begin
            stale[gnt_q] <= 1'b1;
          end
          if (bus.ram_ack) begin
            ram_req_q <= 1'b0;
            busy_q    <= 1'b0;
            state     <= IDLE;
            if (!stale[gnt_q] && !bus.port_req[gnt_q]) begin
              port_data_q[gnt_q*32 +: 32] <= bus.ram_data;
              port_rdy_q[gnt_q]           <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.port_data = port_data_q;
  assign bus.port_rdy  = port_rdy_q;
  assign bus.ram_req   = ram_req_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ga23_sdr_responder.sv
// Bench for ga23_sdr_responder: directed scenarios, then randomized traffic.
// A transaction-level reference model predicts every output on every cycle.
// The bench acts as both the layers and the SDRAM controller.
module tb_ga23_sdr_responder;
  localparam int N  = 3;
  localparam int AW = 22;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ga23_sdr_responder_if #(.NUM_PORTS(N), .ADDR_W(AW)) bus ();

  ga23_sdr_responder #(.NUM_PORTS(N), .ADDR_W(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, at the level of requests and reads.
  bit              m_pend [N];
  logic [AW-1:0]   m_addr [N];
  logic [31:0]     m_data [N];
  int              m_owner;
  bit              m_sup;
  int              m_rr;
  logic            m_req;
  logic [AW-1:0]   m_ram_addr;
  logic [N-1:0]    m_rdy;

  // Addresses observed on the DUT each time ram_req rises.
  logic [AW-1:0]   obs_log [$];
  logic            prev_req;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*AW-1:0] pa(input int p, input logic [AW-1:0] a);
    logic [N*AW-1:0] v;
    v = '0;
    v[p*AW +: AW] = a;
    return v;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      m_pend[p] = 1'b0;
      m_addr[p] = '0;
      m_data[p] = '0;
    end
    m_owner    = -1;
    m_sup      = 1'b0;
    m_rr       = 0;
    m_req      = 1'b0;
    m_ram_addr = '0;
    m_rdy      = '0;
  endtask

  // Predict the effect of one clock edge, given the inputs presented for it.
  task automatic model_edge(input logic [N-1:0] req, input logic [N*AW-1:0] addr,
                            input logic ack, input logic [31:0] d);
    int g;
    int p;
    m_rdy = '0;
    if (m_owner < 0) begin
      g = -1;
      for (int k = N - 1; k >= 0; k--) begin
`ifdef GA23_SDR_FIXED_PRIO_EN
        p = k;
`else
        p = (m_rr + k) % N;
`endif
        if (m_pend[p]) g = p;
      end
      if (g >= 0) begin
        m_req      = 1'b1;
        m_ram_addr = m_addr[g];
        m_pend[g]  = 1'b0;
        m_sup      = 1'b0;
        m_owner    = g;
        m_rr       = (g + 1) % N;
      end
    end else begin
      if (req[m_owner]) m_sup = 1'b1;
      if (ack) begin
        if (!m_sup) begin
          m_data[m_owner] = d;
          m_rdy[m_owner]  = 1'b1;
        end
        m_req   = 1'b0;
        m_owner = -1;
      end
    end
    for (int q = 0; q < N; q++) begin
      if (req[q]) begin
        m_pend[q] = 1'b1;
        m_addr[q] = addr[q*AW +: AW];
      end
    end
  endtask

  task automatic check_all();
    logic [N*32-1:0] exp_data;
    for (int p = 0; p < N; p++) exp_data[p*32 +: 32] = m_data[p];
    check("ram_req",   bus.ram_req,   m_req);
    check("busy",      bus.busy,      m_req);
    check("ram_addr",  bus.ram_addr,  m_ram_addr);
    check("port_rdy",  bus.port_rdy,  m_rdy);
    check("port_data", bus.port_data, exp_data);
    if (bus.ram_req === 1'b1 && prev_req !== 1'b1) obs_log.push_back(bus.ram_addr);
    prev_req = bus.ram_req;
  endtask

  // One clock: inputs applied at the falling edge, outputs checked at the next one.
  task automatic step(input logic [N-1:0] req, input logic [N*AW-1:0] addr,
                      input logic ack, input logic [31:0] d);
    bus.port_req  = req;
    bus.port_addr = addr;
    bus.ram_ack   = ack;
    bus.ram_data  = d;
    model_edge(req, addr, ack, d);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, 1'b0, 32'h0);
  endtask

  // Wait (bounded) for ram_req, then ack after 'delay' cycles with data d.
  task automatic serve(input int delay, input logic [31:0] d, output int waited);
    waited = 0;
    while (bus.ram_req !== 1'b1 && waited < 20) begin
      idle(1);
      waited++;
    end
    check("serve_req_seen", bus.ram_req, 1'b1);
    idle(delay - 1);
    step('0, '0, 1'b1, d);
  endtask

  task automatic do_reset();
    bus.port_req  = '0;
    bus.port_addr = '0;
    bus.ram_ack   = 1'b0;
    bus.ram_data  = '0;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_ram_req",   bus.ram_req,   1'b0);
    check("rst_busy",      bus.busy,      1'b0);
    check("rst_port_rdy",  bus.port_rdy,  3'b000);
    check("rst_port_data", bus.port_data, 96'h0);
    check("rst_ram_addr",  bus.ram_addr,  22'h0);
    @(negedge clk);
    reset_n  = 1'b1;
    prev_req = 1'b0;
    obs_log.delete();
  endtask

  initial begin
    int w;
    bus.port_req  = '0;
    bus.port_addr = '0;
    bus.ram_ack   = 1'b0;
    bus.ram_data  = '0;
    prev_req      = 1'b0;

    // Single request on port 1, acked 4 cycles after ram_req.
    do_reset();
    step(3'b010, pa(1, 22'h12345), 1'b0, 32'h0);
    check("t1_no_req_yet", bus.ram_req, 1'b0);
    serve(4, 32'hDEADBEEF, w);
    check("t1_latency",    w, 1);
    check("t1_addr",       obs_log[0], 22'h12345);
    check("t1_rdy",        bus.port_rdy, 3'b010);
    check("t1_data1",      bus.port_data[63:32], 32'hDEADBEEF);
    check("t1_data0",      bus.port_data[31:0], 32'h0);
    check("t1_data2",      bus.port_data[95:64], 32'h0);
    idle(1);
    check("t1_rdy_once",   bus.port_rdy, 3'b000);
    check("t1_idle_after", bus.ram_req, 1'b0);

    // Arbitration order over two bursts.
    do_reset();
    step(3'b111, pa(0, 22'h100) | pa(1, 22'h200) | pa(2, 22'h300), 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      serve(3, $urandom, w);
      check("rr_b2b_gap", w, 1);
    end
    step(3'b001, pa(0, 22'h150), 1'b0, 32'h0);
    serve(3, $urandom, w);
    step(3'b111, pa(0, 22'h110) | pa(1, 22'h210) | pa(2, 22'h310), 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) serve(3, $urandom, w);
    check("rr_count", obs_log.size(), 7);
    check("rr_b1_0", obs_log[0], 22'h100);
    check("rr_b1_1", obs_log[1], 22'h200);
    check("rr_b1_2", obs_log[2], 22'h300);
    check("rr_solo", obs_log[3], 22'h150);
`ifdef GA23_SDR_FIXED_PRIO_EN
    check("rr_b2_0", obs_log[4], 22'h110);
    check("rr_b2_1", obs_log[5], 22'h210);
    check("rr_b2_2", obs_log[6], 22'h310);
`else
    check("rr_b2_0", obs_log[4], 22'h210);
    check("rr_b2_1", obs_log[5], 22'h310);
    check("rr_b2_2", obs_log[6], 22'h110);
`endif

    // Port 2 re-requests while its read is in flight.
    do_reset();
    step(3'b100, pa(2, 22'h400), 1'b0, 32'h0);
    idle(1);
    step(3'b100, pa(2, 22'h480), 1'b0, 32'h0);
    step('0, '0, 1'b1, 32'hAAAA0000);
    check("sup_no_rdy", bus.port_rdy, 3'b000);
    check("sup_data",   bus.port_data[95:64], 32'h0);
    serve(2, 32'hBBBB0000, w);
    check("sup_reissue_gap", w, 1);
    check("sup_addr2", obs_log[1], 22'h480);
    check("sup_rdy",   bus.port_rdy, 3'b100);
    check("sup_data2", bus.port_data[95:64], 32'hBBBB0000);

    // Port 0 overwrites its pending address while port 1 holds the bus.
    do_reset();
    step(3'b010, pa(1, 22'h111), 1'b0, 32'h0);
    idle(1);
    step(3'b001, pa(0, 22'h010), 1'b0, 32'h0);
    step(3'b001, pa(0, 22'h020), 1'b0, 32'h0);
    step('0, '0, 1'b1, 32'h11111111);
    serve(2, 32'h22222222, w);
    idle(3);
    check("ovr_count", obs_log.size(), 2);
    check("ovr_addr",  obs_log[1], 22'h020);
    check("ovr_data0", bus.port_data[31:0], 32'h22222222);

    // Reset while a read is outstanding and another is pending.
    do_reset();
    step(3'b011, pa(0, 22'h0AA) | pa(1, 22'h0BB), 1'b0, 32'h0);
    idle(1);
    check("mid_busy", bus.busy, 1'b1);
    do_reset();
    step('0, '0, 1'b1, 32'hCAFEF00D);
    check("mid_ack_rdy", bus.port_rdy, 3'b000);
    idle(3);
    check("mid_no_req",  bus.ram_req, 1'b0);
    check("mid_data",    bus.port_data, 96'h0);

    // Spurious ack in IDLE.
    step('0, '0, 1'b1, 32'h55555555);
    check("spur_rdy",  bus.port_rdy, 3'b000);
    check("spur_busy", bus.busy, 1'b0);
    check("spur_data", bus.port_data, 96'h0);

    // Randomized traffic, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0]    r;
      logic [N*AW-1:0] a;
      logic            k;
      r = '0;
      a = '0;
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(0, 7) == 0) r[p] = 1'b1;
        a[p*AW +: AW] = AW'($urandom);
      end
      k = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      else step(r, a, k, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ga23_sdr_responder.md
Name: ga23_sdr_responder

Overview:
- Services tile-row fetch requests from the GA23 background layers.
- Each layer port issues a single-cycle sdr_req pulse with a 22-bit sdr_addr and expects 32-bit sdr_data plus an sdr_rdy pulse.
- The block latches requests per port, arbitrates among ports, and runs one read at a time on the shared SDRAM read channel.
- It returns data to the owning port and discards results that a newer request on the same port has superseded.

Parameters:
- NUM_PORTS, 3, number of layer request ports (1..8).
- ADDR_W, 22, width of the per-port and SDRAM address.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- port_req  input  NUM_PORTS  per-port single-cycle request pulse (layer sdr_req).
- port_addr  input  NUM_PORTS*ADDR_W  per-port address, port p at bits [p*ADDR_W +: ADDR_W].
- port_data  output  NUM_PORTS*32  per-port returned row data, port p at [p*32 +: 32].
- port_rdy  output  NUM_PORTS  per-port single-cycle data-valid pulse.
- ram_req  output  1  read request to SDRAM controller, level, held until ack.
- ram_addr  output  ADDR_W  read address, stable while ram_req=1.
- ram_ack  input  1  single-cycle pulse: ram_data valid this cycle.
- ram_data  input  32  read data.
- busy  output  1  high while a read is outstanding (state BUSY).

Behaviour:
- Reset (async, reset_n=0): all pending flags, stale flags, port_rdy, ram_req, busy = 0; port_data, ram_addr = 0; state IDLE; round-robin pointer = 0.
- Request capture, every edge: port_req[p]=1 -> pending[p] <= 1, addr_q[p] <= port_addr[p]. A new pulse while pending overwrites the address; the latest request wins.
- FSM IDLE:
  - If any pending bit is set, the grant g is the first pending port at or after rr_ptr, searching upward and wrapping.
  - Next edge: ram_req <= 1, ram_addr <= addr_q[g], pending[g] <= 0 (unless port_req[g] is also high that edge), stale[g] <= 0, busy <= 1, state BUSY, rr_ptr <= (g+1) mod NUM_PORTS.
  - A pending bit set on that same edge is not considered until the next IDLE cycle.
- FSM BUSY:
  - port_req[g]=1 on any edge while BUSY, including the ack edge, sets stale[g].
  - On the edge where ram_ack=1: ram_req <= 0, busy <= 0, state IDLE.
  - If stale[g]=0 and there is no same-edge port_req[g]: port_data[g] <= ram_data and port_rdy[g] <= 1 for exactly one cycle.
  - Otherwise the data is dropped, port_data[g] is unchanged and no rdy pulse is issued; the newer request stays pending.
- Latency: request pulse at edge n -> ram_req high after edge n+1 (if IDLE). ram_ack at edge m -> port_rdy high after edge m, data already updated. Back-to-back: the next ram_req rises one cycle after ack (one IDLE cycle).
- port_data holds its last delivered value indefinitely. port_rdy is never high for two consecutive cycles on the same port.
- ram_ack while IDLE (spurious, or arriving after a mid-read reset) is ignored.
- Reset mid-operation drops ram_req immediately. The SDRAM controller must tolerate an abandoned request.
- Width rules: ram_addr is exactly the latched port address, with no translation. Ports with index >= NUM_PORTS do not exist.

Optional Feature:
- Macro: GA23_SDR_FIXED_PRIO_EN.
- Defined: fixed priority, lowest port index wins every arbitration; rr_ptr is not implemented.
- Undefined (default): round-robin as specified above.
- Capture, stale and latency rules are identical in both builds.

Test Plan:
- Single request: port 1 pulses with addr 0x12345; controller acks 4 cycles after ram_req with data 0xDEADBEEF -> ram_addr=0x12345; port_rdy[1] pulses once the cycle after ack; port_data[1]=0xDEADBEEF; ports 0 and 2 unchanged.
- Round-robin: ports 0, 1 and 2 pulse on the same cycle (addrs 0x100, 0x200, 0x300), fixed 3-cycle ack -> service order 0, 1, 2. A second burst with all three pending after port 0 was last served -> order 1, 2, 0. With GA23_SDR_FIXED_PRIO_EN the order is always 0, 1, 2.
- Supersede in flight: port 2 requests 0x400; while BUSY, port 2 requests 0x480; ack returns 0xAAAA0000 -> no rdy and data unchanged. A second read is issued at 0x480; ack 0xBBBB0000 -> port_rdy[2] pulses with data 0xBBBB0000.
- Overwrite while pending: port 0 requests 0x010 then 0x020 on the next cycle while port 1 holds the bus -> only 0x020 is issued for port 0.
- Reset mid-read: assert reset_n=0 while BUSY -> ram_req=0 and busy=0 immediately, all pending cleared. Release reset, then pulse ram_ack -> no port_rdy, state stays IDLE.
- Spurious ack in IDLE with no pending requests -> no outputs change.
